// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache with 4-word lines, refilled via a
// request/valid handshake; hits answer combinationally with zero added latency.
module icache_fetch #(
  parameter int INDEX_BITS = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_read,
  input  logic [15:0] cpu_addr,
  output logic [15:0] cpu_data,
  output logic        cpu_ready,
  output logic        cpu_stall,
  input  logic        invalidate,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [63:0] mem_rdata,
  input  logic        mem_valid,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 14 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WAIT, FILL} state_t;

  state_t state, state_next;

  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [63:0]           data_mem [LINES];
  logic [LINES-1:0]      valid;
  logic                  inval_pend;
  logic [15:0]           miss_addr;

  logic [INDEX_BITS-1:0] cpu_index, miss_index;
  logic [TAG_BITS-1:0]   cpu_tag, miss_tag;
  logic [63:0]           cpu_line;
  logic                  hit, miss;

  assign cpu_index  = cpu_addr[INDEX_BITS+1:2];
  assign cpu_tag    = cpu_addr[15:INDEX_BITS+2];
  assign miss_index = miss_addr[INDEX_BITS+1:2];
  assign miss_tag   = miss_addr[15:INDEX_BITS+2];
  assign cpu_line   = data_mem[cpu_index];

  assign hit  = (state == IDLE) && cpu_read && valid[cpu_index] &&
                (tag_mem[cpu_index] == cpu_tag);
  assign miss = (state == IDLE) && cpu_read && !hit;

  assign cpu_ready = hit;
  assign cpu_stall = cpu_read && !hit;
  assign cpu_data  = hit ? cpu_line[{cpu_addr[1:0], 4'b0000} +: 16] : 16'h0000;
  assign mem_req   = (state == WAIT);
  assign mem_addr  = mem_req ? {miss_addr[15:2], 2'b00} : 16'h0000;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (miss) state_next = WAIT;
      WAIT:    if (mem_valid) state_next = FILL;
      FILL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state      <= IDLE;
      valid      <= '0;
      inval_pend <= 1'b0;
      miss_addr  <= 16'h0000;
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else begin
      state <= state_next;

      if (miss) miss_addr <= cpu_addr;

      if (hit && hit_count != 16'hFFFF)   hit_count  <= hit_count + 16'd1;
      if (miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;

      // A flush seen during a refill is deferred so the fresh line is dropped too.
      if (state == IDLE && invalidate)                       valid <= '0;
      else if (state == FILL && (inval_pend || invalidate))  valid <= '0;
      else if (state == WAIT && mem_valid)                   valid[miss_index] <= 1'b1;

      if (state == FILL)                   inval_pend <= 1'b0;
      else if (state == WAIT && invalidate) inval_pend <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are not reset; valid bits alone gate their use, which keeps them RAM-mappable.
  always_ff @(posedge clk) begin
    if (!reset_n && state == WAIT && mem_valid) begin
      data_mem[miss_index] <= mem_rdata;
      tag_mem[miss_index]  <= miss_tag;
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: cold miss, reuse, conflict, redirect,
// invalidate (idle and mid-refill) and reset during a refill.
module tb_icache_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_read;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_data;
  logic        cpu_ready;
  logic        cpu_stall;
  logic        invalidate;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [63:0] mem_rdata;
  logic        mem_valid;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int          checks = 0;
  int          errors = 0;
  int          stalls;
  int          stall_bad;
  int          req_n;
  logic [15:0] req_addr [4];

  icache_fetch #(.INDEX_BITS(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_read   (cpu_read),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_ready  (cpu_ready),
    .cpu_stall  (cpu_stall),
    .invalidate (invalidate),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Backing-memory contents per line address.
  function automatic logic [63:0] line_for(input logic [15:0] a);
    logic [15:0] b;
    b = 16'h1000 + a;
    case (a)
      16'h0000: return 64'h0004_0003_0002_0001;
      16'h0020: return 64'h00AD_00AC_00AB_00AA;
      default:  return {b + 16'd3, b + 16'd2, b + 16'd1, b};
    endcase
  endfunction

  // Runs from the current cycle until cpu_ready, acting as the memory: mem_valid
  // is pulsed in the fourth cycle mem_req is high. Optional redirect/invalidate
  // at a given cycle index (cycle 0 = the cycle this task is entered).
  task automatic run_fetch(input string tag, input int redir_cyc,
                           input logic [15:0] redir_addr, input int inval_cyc);
    int req_cycles;
    bit done;
    req_cycles = 0;
    done       = 1'b0;
    stalls     = 0;
    stall_bad  = 0;
    req_n      = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc == redir_cyc) cpu_addr = redir_addr;
      invalidate = (cyc == inval_cyc);
      if (mem_req) begin
        req_cycles++;
        if (req_cycles == 1 && req_n < 4) begin
          req_addr[req_n] = mem_addr;
          req_n++;
        end
      end else begin
        req_cycles = 0;
      end
      mem_valid = mem_req && (req_cycles == 4);
      mem_rdata = mem_valid ? line_for(mem_addr) : 64'h0;
      #4;
      if (cpu_ready) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (!cpu_stall) stall_bad++;
        tick();
      end
    end
    invalidate = 1'b0;
    mem_valid  = 1'b0;
    mem_rdata  = 64'h0;
    chk({tag, " reached ready"}, 64'(done), 64'(1));
  endtask

  initial begin
    reset_n    = 1'b1;
    cpu_read   = 1'b0;
    cpu_addr   = 16'h0000;
    invalidate = 1'b0;
    mem_valid  = 1'b0;
    mem_rdata  = 64'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #4;
    chk("rst mem_req",    64'(mem_req),    64'(0));
    chk("rst mem_addr",   64'(mem_addr),   64'(0));
    chk("rst cpu_ready",  64'(cpu_ready),  64'(0));
    chk("rst cpu_data",   64'(cpu_data),   64'(0));
    chk("rst cpu_stall",  64'(cpu_stall),  64'(0));
    chk("rst hit_count",  64'(hit_count),  64'(0));
    chk("rst miss_count", 64'(miss_count), 64'(0));
    tick();

    // Cold miss on 0x0000
    cpu_read = 1'b1;
    cpu_addr = 16'h0000;
    run_fetch("cold", -1, 16'h0, -1);
    chk("cold stalls",     64'(stalls),      64'(6));
    chk("cold stall pin",  64'(stall_bad),   64'(0));
    chk("cold req count",  64'(req_n),       64'(1));
    chk("cold mem_addr",   64'(req_addr[0]), 64'(16'h0000));
    chk("cold data",       64'(cpu_data),    64'(16'h0001));
    chk("cold miss_count", 64'(miss_count),  64'(1));
    chk("cold hit_count",  64'(hit_count),   64'(0));

    // Line reuse: words 1..3 hit back to back
    for (int a = 1; a < 4; a++) begin
      tick();
      cpu_addr = 16'(a);
      #4;
      chk("reuse ready", 64'(cpu_ready), 64'(1));
      chk("reuse data",  64'(cpu_data),  64'(a + 1));
    end
    tick();
    cpu_read = 1'b0;
    #4;
    chk("reuse hit_count",  64'(hit_count),  64'(4));
    chk("reuse miss_count", 64'(miss_count), 64'(1));
    chk("idle no stall",    64'(cpu_stall),  64'(0));
    chk("idle data zero",   64'(cpu_data),   64'(0));

    // Conflict: 0x0020 evicts line 0, then 0x0000 misses again
    tick();
    cpu_read = 1'b1;
    cpu_addr = 16'h0020;
    run_fetch("conflict", -1, 16'h0, -1);
    chk("conflict stalls",   64'(stalls),      64'(6));
    chk("conflict mem_addr", 64'(req_addr[0]), 64'(16'h0020));
    chk("conflict data",     64'(cpu_data),    64'(16'h00AA));
    tick();
    cpu_addr = 16'h0000;
    run_fetch("refetch0", -1, 16'h0, -1);
    chk("refetch0 stalls",     64'(stalls),     64'(6));
    chk("refetch0 data",       64'(cpu_data),   64'(16'h0001));
    chk("refetch0 miss_count", 64'(miss_count), 64'(3));

    // Redirect while waiting: 0x0044 still fills, then 0x0010 misses
    tick();
    cpu_addr = 16'h0044;
    run_fetch("redirect", 2, 16'h0010, -1);
    chk("redirect stalls",     64'(stalls),      64'(12));
    chk("redirect req count",  64'(req_n),       64'(2));
    chk("redirect 1st addr",   64'(req_addr[0]), 64'(16'h0044));
    chk("redirect 2nd addr",   64'(req_addr[1]), 64'(16'h0010));
    chk("redirect data",       64'(cpu_data),    64'(16'h1010));
    chk("redirect miss_count", 64'(miss_count),  64'(5));
    tick();
    cpu_addr = 16'h0044;
    #4;
    chk("0x44 filled ready", 64'(cpu_ready), 64'(1));
    chk("0x44 filled data",  64'(cpu_data),  64'(16'h1044));
    tick();
    cpu_addr = 16'h0047;
    #4;
    chk("0x47 data", 64'(cpu_data), 64'(16'h1047));

    // Invalidate in IDLE: same-cycle hit uses the old valid bits
    tick();
    cpu_addr   = 16'h0000;
    invalidate = 1'b1;
    #4;
    chk("inval same-cycle ready", 64'(cpu_ready), 64'(1));
    chk("inval same-cycle data",  64'(cpu_data),  64'(16'h0001));
    tick();
    invalidate = 1'b0;
    run_fetch("post-inval", -1, 16'h0, -1);
    chk("post-inval stalls",     64'(stalls),     64'(6));
    chk("post-inval miss_count", 64'(miss_count), 64'(6));

    // Invalidate during WAIT: filled line is dropped, same address misses again
    tick();
    cpu_addr = 16'h0008;
    run_fetch("wait-inval", -1, 16'h0, 2);
    chk("wait-inval stalls",     64'(stalls),      64'(12));
    chk("wait-inval req count",  64'(req_n),       64'(2));
    chk("wait-inval 2nd addr",   64'(req_addr[1]), 64'(16'h0008));
    chk("wait-inval data",       64'(cpu_data),    64'(16'h1008));
    chk("wait-inval miss_count", 64'(miss_count),  64'(8));
    tick();
    cpu_read = 1'b0;
    #4;
    chk("hit_count before reset", 64'(hit_count), 64'(12));

    // Reset in the middle of a refill, followed by a late mem_valid
    tick();
    cpu_read = 1'b1;
    cpu_addr = 16'h0030;
    #4;
    chk("rmid miss", 64'(cpu_ready), 64'(0));
    tick();
    #4;
    chk("rmid mem_req",    64'(mem_req),    64'(1));
    chk("rmid mem_addr",   64'(mem_addr),   64'(16'h0030));
    chk("rmid miss_count", 64'(miss_count), 64'(9));
    tick();
    reset_n = 1'b1;
    tick();
    reset_n   = 1'b0;
    cpu_read  = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    #4;
    chk("rmid req dropped",   64'(mem_req),    64'(0));
    chk("rmid hit cleared",   64'(hit_count),  64'(0));
    chk("rmid miss cleared",  64'(miss_count), 64'(0));
    tick();
    mem_valid = 1'b0;
    mem_rdata = 64'h0;
    #4;
    chk("late valid ignored", 64'(mem_req), 64'(0));
    tick();
    cpu_read = 1'b1;
    cpu_addr = 16'h0030;
    run_fetch("after rmid", -1, 16'h0, -1);
    chk("after rmid stalls",     64'(stalls),      64'(6));
    chk("after rmid mem_addr",   64'(req_addr[0]), 64'(16'h0030));
    chk("after rmid data",       64'(cpu_data),    64'(16'h1030));
    chk("after rmid miss_count", 64'(miss_count),  64'(1));
    chk("after rmid hit_count",  64'(hit_count),   64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache between the PC/BTB fetch logic and instruction memory.
- Sits directly upstream of the pipeline's IF/ID latch: its cpu_data drives the datapath's Imemdata input.
- cpu_stall feeds the hazard/control unit, which holds PCwrite and the IF/ID latch while a miss is serviced.
- Refills 4-word lines from a slower backing memory through a request/valid handshake.

Parameters:
- INDEX_BITS, 3: number of lines is 2^INDEX_BITS.
- Fixed, not parameters: 4 words per line; tag width is 14-INDEX_BITS (11 at default).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-high reset (high = reset, despite the name).
- cpu_read  in  1  fetch request, qualifies cpu_addr.
- cpu_addr  in  16  word address from PC; offset [1:0], index [INDEX_BITS+1:2], tag [15:INDEX_BITS+2].
- cpu_data  out  16  fetched instruction; valid only when cpu_ready=1.
- cpu_ready  out  1  hit this cycle.
- cpu_stall  out  1  cpu_read & ~cpu_ready.
- invalidate  in  1  clear all valid bits.
- mem_req  out  1  line refill request.
- mem_addr  out  16  line-aligned address, bits [1:0]=0.
- mem_rdata  in  64  refill line; word0=[15:0] … word3=[63:48].
- mem_valid  in  1  mem_rdata valid; one-cycle pulse.
- hit_count  out  16  saturating hit counter.
- miss_count  out  16  saturating miss counter.

Behaviour:
- Reset (sampled at posedge with reset_n=1):
  - State goes to IDLE and all valid bits clear.
  - mem_req=0, mem_addr=0, cpu_ready=0, cpu_data=16'h0000, hit_count=0, miss_count=0.
  - Pending invalidate clears.
  - Tag and data arrays need not be reset.
- Hit (IDLE):
  - Condition: cpu_read & valid[index] & tag match.
  - Response is combinational in the same cycle: cpu_ready=1, cpu_data=line word at cpu_addr[1:0]. Zero added fetch latency.
  - hit_count increments by 1 per ready cycle, saturating at 16'hFFFF. A CPU holding the address for a data stall counts once per cycle.
- When not ready: cpu_ready=0 and cpu_data=16'h0000 whenever ready is not asserted (the datapath injects a bubble).
- Miss (IDLE):
  - Condition: cpu_read & ~hit.
  - Next cycle: state goes to WAIT, cpu_addr is latched as miss_addr, and miss_count increments (saturating).
- WAIT:
  - mem_req=1 and mem_addr={miss_addr[15:2],2'b00}, both held steady until mem_valid.
  - cpu_ready=0, so cpu_stall=cpu_read.
  - On mem_valid: write mem_rdata into data[miss index], write the tag, set valid; go to FILL. mem_req drops in the FILL cycle.
- FILL:
  - One cycle; cpu_ready=0 and arrays are stable.
  - Next state is IDLE, which re-evaluates the current cpu_addr.
  - Miss penalty = memory latency (mem_req rise to mem_valid) + 2 cycles to the first ready.
- Address change during a miss (e.g. a branch or jump redirect): the refill for the latched miss_addr still completes. IDLE then re-evaluates the new cpu_addr, which may miss again. No request is aborted.
- cpu_read=0 in IDLE: cpu_ready=0, cpu_stall=0, no state change, no counting.
- invalidate:
  - In IDLE: all valid bits clear at that edge. Any hit check in the same cycle uses the pre-clear state.
  - In WAIT/FILL: latched as pending; applied on entry to IDLE, so the just-filled line also becomes invalid.
- mem_valid outside WAIT is ignored (covers a late response after reset mid-miss).
- Reset mid-miss: state goes to IDLE at that edge and mem_req drops next cycle; no array write.
- Lines are never dirty, and there is no write port.

Test Plan:
- Cold miss: reset, then cpu_read=1, cpu_addr=16'h0000. The memory model returns 64'h0004_0003_0002_0001 four cycles after mem_req.
  - Required: mem_addr=16'h0000; cpu_stall=1 for 6 cycles; then cpu_ready=1, cpu_data=16'h0001; miss_count=1.
- Line reuse: after the cold miss, step cpu_addr through 1, 2, 3.
  - Required: ready each cycle with data 0002, 0003, 0004; hit_count=4, miss_count=1.
- Conflict: fetch 16'h0020 (same index 0, tag 1) with line data 64'h…_00AA in word0.
  - Required: a miss, cpu_data=16'h00AA after the refill.
  - Then 16'h0000 misses again: miss_count=3.
- Redirect mid-miss: miss on 16'h0044; while in WAIT, change cpu_addr to 16'h0010.
  - Required: the 16'h0044 line fills; then 16'h0010 issues a new mem_req with mem_addr=16'h0010.
- Invalidate: with line 0 valid, pulse invalidate in IDLE, then fetch 16'h0000.
  - Required: a miss.
  - Also pulse invalidate during WAIT. Required: after FILL, the same address misses again.
- Reset mid-miss: assert reset_n=1 in WAIT; the model then returns mem_valid.
  - Required: no array write, counters=0, and the next fetch of that address misses.
